// File: rtl/demux_1x8_deser_pkg.sv
// Shared constants and state encoding for the 1-to-8 demultiplexer/deserializer.
// Imported by the interface, the lane decoder and the top.
package demux_1x8_deser_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1x8_deser_if.sv
// Beat input, frame handshake and lane outputs of demux_1x8_deser.
// The master side is the source/consumer; the slave side is the block.
interface demux_1x8_deser_if #(
    parameter int WIDTH = 1
);
    import demux_1x8_deser_pkg::*;

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             mode;
    logic [IDX_W-1:0] sel;
    logic             frame_ack;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [IDX_W-1:0] lane;
    logic             frame_valid;

    modport master (
        output din, din_valid, mode, sel, frame_ack,
        input  din_ready, a, b, c, d, e, f, g, h, lane, frame_valid
    );

    modport slave (
        input  din, din_valid, mode, sel, frame_ack,
        output din_ready, a, b, c, d, e, f, g, h, lane, frame_valid
    );

endinterface

// File: rtl/demux_1x8_deser_demux.sv
// Combinational 3-to-8 one-hot decoder producing per-lane write enables.
// All enables are low when en is low.
module demux_1x8
    import demux_1x8_deser_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [LANES-1:0] oh
);

    always_comb begin
        oh = '0;
        if (en) begin
            oh[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_1x8_deser.sv
// Routes one input stream onto eight registered lanes, either addressed by sel
// or filled in order as a frame released under a valid/ack handshake.
module demux_1x8_deser
    import demux_1x8_deser_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    demux_1x8_deser_if.slave  bus
);

    state_t           state;
    logic [IDX_W-1:0] lane;
    logic             frame_valid;
    logic [WIDTH-1:0] lanes [LANES];
    logic             accept;
    logic [IDX_W-1:0] wr_idx;
    logic [LANES-1:0] wr_en;

    // Ready depends only on registered state and mode, never on din_valid.
    assign bus.din_ready = (bus.mode == MODE_ADDR) || (state == ST_FILL);
    assign accept        = bus.din_valid && bus.din_ready;
    assign wr_idx        = (bus.mode == MODE_SEQ) ? lane : bus.sel;

    demux_1x8 u_demux (
        .idx (wr_idx),
        .en  (accept),
        .oh  (wr_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FILL;
            lane        <= '0;
            frame_valid <= 1'b0;
        end else if (bus.mode == MODE_ADDR) begin
            // Leaving SEQ abandons any partial or held frame.
            state       <= ST_FILL;
            lane        <= '0;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        lane <= lane + 1'b1;
                        if (lane == IDX_W'(LANES - 1)) begin
                            state       <= ST_HOLD;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.frame_ack) begin
                        state       <= ST_FILL;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_FILL;
                    lane        <= '0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr_en[i]) begin
                    lanes[i] <= bus.din;
                end
            end
        end
    end

    assign bus.a           = lanes[0];
    assign bus.b           = lanes[1];
    assign bus.c           = lanes[2];
    assign bus.d           = lanes[3];
    assign bus.e           = lanes[4];
    assign bus.f           = lanes[5];
    assign bus.g           = lanes[6];
    assign bus.h           = lanes[7];
    assign bus.lane        = lane;
    assign bus.frame_valid = frame_valid;

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Randomized self-checking bench for demux_1x8_deser against a frame-level
// reference model (lane array, beat count, frame-full flag).
module tb_demux_1x8_deser;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    int   m_lane [8];
    int   m_cnt;
    bit   m_full;

    demux_1x8_deser_if #(.WIDTH(W)) bus ();

    demux_1x8_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_ready();
        return (bus.mode == 1'b0 || !m_full) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_lane[i] = 0;
        m_cnt  = 0;
        m_full = 0;
    endtask

    task automatic check_outputs(input string ph);
        int got [8];
        got[0] = int'(bus.a); got[1] = int'(bus.b); got[2] = int'(bus.c); got[3] = int'(bus.d);
        got[4] = int'(bus.e); got[5] = int'(bus.f); got[6] = int'(bus.g); got[7] = int'(bus.h);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s lane_out[%0d]", ph, i), got[i], m_lane[i]);
        end
        check({ph, " lane"}, int'(bus.lane), m_full ? 0 : m_cnt);
        check({ph, " frame_valid"}, int'(bus.frame_valid), int'(m_full));
    endtask

    // One clock: ready checked mid-cycle, model advanced on the edge, outputs checked after.
    task automatic cycle();
        bit acc;
        int d, s;
        bit md, ack;
        @(negedge clk);
        check("din_ready", int'(bus.din_ready), exp_ready());
        acc = bus.din_valid && (exp_ready() == 1);
        d   = int'(bus.din);
        s   = int'(bus.sel);
        md  = bus.mode;
        ack = bus.frame_ack;
        @(posedge clk);
        #1;
        if (!md) begin
            if (acc) m_lane[s] = d;
            m_cnt  = 0;
            m_full = 0;
        end else if (m_full) begin
            if (ack) m_full = 0;
        end else if (acc) begin
            m_lane[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt  = 0;
                m_full = 1;
            end
        end
        check_outputs("post");
    endtask

    task automatic drive(input bit md, input bit v, input int d, input int s, input bit ack);
        bus.mode      = md;
        bus.din_valid = v;
        bus.din       = W'(d);
        bus.sel       = 3'(s);
        bus.frame_ack = ack;
    endtask

    task automatic async_reset_pulse();
        #1 reset = 1'b1;
        #1;
        model_clear();
        check_outputs("rst");
        check("rst din_ready", int'(bus.din_ready), 1);
        #1 reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset din_ready", int'(bus.din_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Addressed walk across all lanes, then clear d only.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1 + (i % 15), i, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b1, 0, 3, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, $urandom_range(15), $urandom_range(7), 1'b0);
            cycle();
        end

        // Async reset between edges wipes everything.
        async_reset_pulse();

        // Sequential fill 1..8, then hold with pending din and ack.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, i, $urandom_range(7), 1'b0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 9, $urandom_range(7), 1'b0);
            cycle();
        end
        drive(1'b1, 1'b1, 9, 0, 1'b1);
        cycle();
        drive(1'b1, 1'b1, 9, 0, 1'b0);
        cycle();

        // Gapped input.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i % 2) == 0, $urandom_range(15), 0, 1'b0);
            cycle();
        end

        // Mode abort mid-fill, then a full frame from lane a.
        async_reset_pulse();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 10 + i, 0, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 15 - i, 0, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        cycle();

        // Mid-frame async reset.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, $urandom_range(15), 0, 1'b0);
            cycle();
        end
        async_reset_pulse();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(9) != 0), ($urandom_range(3) != 0), $urandom_range(15),
                  $urandom_range(7), ($urandom_range(3) == 0));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
